dpram_req_frontend: RTL and testbench

Request front-end for the inferred true-dual-port RAM (ports A and B: `wren_*`, `rden_*`, `addr_*`, `wdata_*`, `rdata_*`). It takes two independent valid/ready request streams, registers them onto the RAM ports, and resolves same-cycle same-address collisions between A and B. It returns read data through per-port credit-controlled response FIFOs, so requesters can backpressure without losing RAM output. The block sits directly upstream of the RAM, and its RAM-side ports connect 1:1 to it.

---
 rtl/dpram_fe_pkg.sv | 23 ++
 rtl/dpram_req_frontend_if.sv | 31 +++
 rtl/dpram_fe_rsp_fifo.sv | 64 ++++++
 rtl/dpram_req_frontend.sv | 110 +++++++++++
 tb/tb_dpram_req_frontend.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_fe_pkg.sv
// Shared types and constants for the dual-port RAM request front-end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// req_t is the canonical request record at the default geometry; CRED_W sizing
// comes from cred_w() so the counter can hold the full 0..RSP_DEPTH range.
package dpram_fe_pkg;

    localparam int ABITS_DEF = 12;
    localparam int WIDTH_DEF = 72;

    typedef struct packed {
        logic                 we;
        logic [ABITS_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0] wdata;
    } req_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dpram_req_frontend_if.sv
// One requester port of the RAM front-end: request stream in, read responses out.
// Latency: n/a (wires only).
// Backpressure: req_ready from the front-end, rsp_ready from the consumer.
//
// master: requester side (drives req_*, rsp_ready).
// slave:  front-end side (drives req_ready, rsp_valid, rsp_rdata).
interface dpram_req_frontend_if
    import dpram_fe_pkg::*;
#(
    parameter int ABITS = ABITS_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [ABITS-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dpram_fe_rsp_fifo.sv
// Per-port read tracker, response FIFO and credit counter for the RAM front-end.
// Latency: RAM data captured 2 edges after read acceptance; rsp_valid straight from FIFO state.
// Backpressure: credits reserved at acceptance, so the FIFO can never overflow.
//
// Ports: clk/rst; rd_issue (read accepted this cycle); ram_rdata (registered RAM
// output); rsp_valid/rsp_ready/rsp_rdata (consumer side); cred_avail (cred != 0).
module dpram_fe_rsp_fifo
    import dpram_fe_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_issue,
    input  logic [WIDTH-1:0] ram_rdata,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             cred_avail
);
    localparam int CW = cred_w(RSP_DEPTH);
    localparam int PW = $clog2(RSP_DEPTH);

    // rd_pipe[0]: RAM port enabled this cycle; rd_pipe[1]: RAM output holds our data.
    logic [1:0]       rd_pipe;
    logic [WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [CW-1:0]    cred;
    logic             push;
    logic             pop;

    assign push       = rd_pipe[1];
    // Forced low on the reset cycle so stale entries are never presented.
    assign rsp_valid  = (wr_ptr != rd_ptr) && !rst;
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_rdata  = rsp_valid ? mem[rd_ptr[PW-1:0]] : '0;
    assign cred_avail = (cred != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cred    <= CW'(RSP_DEPTH);
        end else begin
            rd_pipe <= {rd_pipe[0], rd_issue};
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({rd_issue, pop})
                2'b10:   cred <= cred - CW'(1);
                2'b01:   cred <= cred + CW'(1);
                default: cred <= cred;
            endcase
        end
    end

    // Storage needs no reset: pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= ram_rdata;
    end

endmodule

// File: rtl/dpram_req_frontend.sv
// Dual-port RAM request front-end: registers A/B requests onto RAM ports, resolves same-address collisions.
// Latency: request to RAM enable 1 edge; read response valid 2 edges after acceptance (FIFO empty).
// Backpressure: req_ready drops on zero read credits or on a collision stall of port B.
//
// Ports: clk, rst (sync, active-high); a/b request+response interfaces (slave
// modport); wren_x/rden_x/addr_x/wdata_x to the RAM; rdata_x from the RAM.
// Build option DPRAM_FE_STRICT_COLLISION_EN: also stall B on A-write/B-read to the
// same address, for RAM styles without A->B write forwarding.
module dpram_req_frontend
    import dpram_fe_pkg::*;
#(
    parameter int ABITS     = ABITS_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dpram_req_frontend_if.slave  a,
    dpram_req_frontend_if.slave  b,
    output logic                 wren_a,
    output logic                 rden_a,
    output logic [ABITS-1:0]     addr_a,
    output logic [WIDTH-1:0]     wdata_a,
    input  logic [WIDTH-1:0]     rdata_a,
    output logic                 wren_b,
    output logic                 rden_b,
    output logic [ABITS-1:0]     addr_b,
    output logic [WIDTH-1:0]     wdata_b,
    input  logic [WIDTH-1:0]     rdata_b
);
    logic a_cred_ok;
    logic b_cred_ok;
    logic same_addr;
    logic stall_b;
    logic a_acc;
    logic b_acc;

    assign same_addr = (a.req_addr == b.req_addr);

    // A always wins a collision; B is held and retries next cycle.
`ifdef DPRAM_FE_STRICT_COLLISION_EN
    assign stall_b = a.req_valid && a.req_we && same_addr;
`else
    // A-write/B-read proceeds: the RAM forwards A's write data to B.
    assign stall_b = a.req_valid && a.req_we && b.req_we && same_addr;
`endif

    // rst doubles as the reset-cycle qualifier: nothing is accepted while it is high.
    assign a.req_ready = !rst && (a.req_we || a_cred_ok);
    assign b.req_ready = !rst && (b.req_we || b_cred_ok) && !stall_b;

    assign a_acc = a.req_valid && a.req_ready;
    assign b_acc = b.req_valid && b.req_ready;

    // Issue registers: enables are one-cycle pulses per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wren_a  <= 1'b0;
            rden_a  <= 1'b0;
            addr_a  <= '0;
            wdata_a <= '0;
            wren_b  <= 1'b0;
            rden_b  <= 1'b0;
            addr_b  <= '0;
            wdata_b <= '0;
        end else begin
            wren_a <= a_acc && a.req_we;
            rden_a <= a_acc && !a.req_we;
            if (a_acc) begin
                addr_a  <= a.req_addr;
                wdata_a <= a.req_wdata;
            end
            wren_b <= b_acc && b.req_we;
            rden_b <= b_acc && !b.req_we;
            if (b_acc) begin
                addr_b  <= b.req_addr;
                wdata_b <= b.req_wdata;
            end
        end
    end

    dpram_fe_rsp_fifo #(
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_a (
        .clk        (clk),
        .rst        (rst),
        .rd_issue   (a_acc && !a.req_we),
        .ram_rdata  (rdata_a),
        .rsp_ready  (a.rsp_ready),
        .rsp_valid  (a.rsp_valid),
        .rsp_rdata  (a.rsp_rdata),
        .cred_avail (a_cred_ok)
    );

    dpram_fe_rsp_fifo #(
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_b (
        .clk        (clk),
        .rst        (rst),
        .rd_issue   (b_acc && !b.req_we),
        .ram_rdata  (rdata_b),
        .rsp_ready  (b.rsp_ready),
        .rsp_valid  (b.rsp_valid),
        .rsp_rdata  (b.rsp_rdata),
        .cred_avail (b_cred_ok)
    );

endmodule

// File: tb/tb_dpram_req_frontend.sv
// Bench for dpram_req_frontend: directed collision/credit/reset cases plus random
// dual-port traffic checked against a reference memory and per-port scoreboards.
// Includes a behavioural true-dual-port RAM with A->B write forwarding.
module tb_dpram_req_frontend;
    import dpram_fe_pkg::*;

    localparam int ABITS     = ABITS_DEF;
    localparam int WIDTH     = WIDTH_DEF;
    localparam int RSP_DEPTH = 4;

    typedef logic [WIDTH-1:0] dat_t;
    typedef logic [ABITS-1:0] adr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic wren_a, rden_a, wren_b, rden_b;
    adr_t addr_a, addr_b;
    dat_t wdata_a, wdata_b;
    dat_t rdata_a = '0;
    dat_t rdata_b = '0;

    dpram_req_frontend_if #(.ABITS(ABITS), .WIDTH(WIDTH)) a_if ();
    dpram_req_frontend_if #(.ABITS(ABITS), .WIDTH(WIDTH)) b_if ();

    dpram_req_frontend #(.ABITS(ABITS), .WIDTH(WIDTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst(rst), .a(a_if), .b(b_if),
        .wren_a(wren_a), .rden_a(rden_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rdata_a),
        .wren_b(wren_b), .rden_b(rden_b), .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rdata_b)
    );

    // Behavioural RAM: registered reads, A->B write forwarding, B->A reads old data.
    dat_t ram [0:(1<<ABITS)-1];
    always @(posedge clk) begin
        if (wren_a) ram[addr_a] <= wdata_a;
        if (wren_b) ram[addr_b] <= wdata_b;
        if (rden_a) rdata_a <= ram[addr_a];
        if (rden_b) rdata_b <= (wren_a && addr_a == addr_b) ? wdata_a : ram[addr_b];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input dat_t obs, input dat_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: memory as seen at each acceptance edge, expected responses per port.
    dat_t ref_mem [adr_t];
    dat_t qa [$];
    dat_t qb [$];
    logic acc_a, acc_b;

    function automatic dat_t ref_rd(input adr_t ad);
        return ref_mem.exists(ad) ? ref_mem[ad] : '0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            check("excl_a", dat_t'(wren_a & rden_a), '0);
            check("excl_b", dat_t'(wren_b & rden_b), '0);
            if (a_if.rsp_valid && a_if.rsp_ready) begin
                if (qa.size() == 0) check("a_rsp_unexpected", dat_t'(1), '0);
                else                check("a_rsp_order", a_if.rsp_rdata, qa.pop_front());
            end
            if (b_if.rsp_valid && b_if.rsp_ready) begin
                if (qb.size() == 0) check("b_rsp_unexpected", dat_t'(1), '0);
                else                check("b_rsp_order", b_if.rsp_rdata, qb.pop_front());
            end
            acc_a = a_if.req_valid && a_if.req_ready;
            acc_b = b_if.req_valid && b_if.req_ready;
            if (acc_a && !a_if.req_we) qa.push_back(ref_rd(a_if.req_addr));
            if (acc_b && !b_if.req_we)
                qb.push_back((acc_a && a_if.req_we && a_if.req_addr == b_if.req_addr)
                             ? a_if.req_wdata : ref_rd(b_if.req_addr));
            if (acc_a && a_if.req_we) ref_mem[a_if.req_addr] = a_if.req_wdata;
            if (acc_b && b_if.req_we) ref_mem[b_if.req_addr] = b_if.req_wdata;
            check("a_no_overflow", dat_t'(qa.size() <= RSP_DEPTH), dat_t'(1));
            check("b_no_overflow", dat_t'(qb.size() <= RSP_DEPTH), dat_t'(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input req_t r);
        a_if.req_valid = 1'b1;
        a_if.req_we    = r.we;
        a_if.req_addr  = r.addr;
        a_if.req_wdata = r.wdata;
    endtask

    task automatic drive_b(input req_t r);
        b_if.req_valid = 1'b1;
        b_if.req_we    = r.we;
        b_if.req_addr  = r.addr;
        b_if.req_wdata = r.wdata;
    endtask

    task automatic idle_a();
        a_if.req_valid = 1'b0;
        a_if.req_we    = 1'b0;
        a_if.req_addr  = '0;
        a_if.req_wdata = '0;
    endtask

    task automatic idle_b();
        b_if.req_valid = 1'b0;
        b_if.req_we    = 1'b0;
        b_if.req_addr  = '0;
        b_if.req_wdata = '0;
    endtask

    // Read on A with an empty FIFO and rsp_ready high: response exactly 2 edges after acceptance.
    task automatic a_read_expect(input string tag, input adr_t ad, input dat_t exp);
        drive_a('{we: 1'b0, addr: ad, wdata: '0});
        #1 check({tag, "_ready"}, dat_t'(a_if.req_ready), dat_t'(1));
        step();
        idle_a();
        check({tag, "_rden"}, dat_t'(rden_a), dat_t'(1));
        check({tag, "_vld_t1"}, dat_t'(a_if.rsp_valid), '0);
        step();
        check({tag, "_vld_t2"}, dat_t'(a_if.rsp_valid), '0);
        step();
        check({tag, "_vld_t3"}, dat_t'(a_if.rsp_valid), dat_t'(1));
        check({tag, "_data"}, a_if.rsp_rdata, exp);
    endtask

    adr_t t4_addr [6];
    dat_t t4_exp  [4];
    int   acc;
    req_t rq;

    initial begin
        rst = 1'b1;
        idle_a();
        idle_b();
        a_if.rsp_ready = 1'b1;
        b_if.rsp_ready = 1'b1;
        step();
        step();
        check("rst_a_ready", dat_t'(a_if.req_ready), '0);
        check("rst_a_rsp_vld", dat_t'(a_if.rsp_valid), '0);
        check("rst_a_rsp_dat", a_if.rsp_rdata, '0);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", dat_t'(a_if.req_ready), dat_t'(1));
        check("post_rst_ram_en", dat_t'({wren_a, rden_a, wren_b, rden_b}), '0);
        check("post_rst_cred_a", dat_t'(dut.u_rsp_a.cred), dat_t'(RSP_DEPTH));

        // Write then read back on A.
        drive_a('{we: 1'b1, addr: 12'h010, wdata: 72'h0A5});
        step();
        idle_a();
        check("t1_wren", dat_t'(wren_a), dat_t'(1));
        check("t1_rden", dat_t'(rden_a), '0);
        check("t1_addr", dat_t'(addr_a), dat_t'(12'h010));
        check("t1_wdata", wdata_a, 72'h0A5);
        a_read_expect("t1_rd", 12'h010, 72'h0A5);
        step();

        // Write/write collision: B held one cycle, B's data ends up in RAM.
        drive_a('{we: 1'b1, addr: 12'h020, wdata: 72'h111});
        drive_b('{we: 1'b1, addr: 12'h020, wdata: 72'h222});
        #1;
        check("t2_a_ready", dat_t'(a_if.req_ready), dat_t'(1));
        check("t2_b_stall", dat_t'(b_if.req_ready), '0);
        step();
        idle_a();
        #1 check("t2_b_retry_ready", dat_t'(b_if.req_ready), dat_t'(1));
        step();
        idle_b();
        check("t2_wren_b", dat_t'(wren_b), dat_t'(1));
        a_read_expect("t2_rd", 12'h020, 72'h222);
        step();

        // A write + B read, same address: B returns the new data either way.
        drive_a('{we: 1'b1, addr: 12'h030, wdata: 72'h333});
        drive_b('{we: 1'b0, addr: 12'h030, wdata: '0});
`ifdef DPRAM_FE_STRICT_COLLISION_EN
        #1 check("t3_b_stall", dat_t'(b_if.req_ready), '0);
        step();
        idle_a();
        #1 check("t3_b_retry_ready", dat_t'(b_if.req_ready), dat_t'(1));
        step();
        idle_b();
`else
        #1 check("t3_b_no_stall", dat_t'(b_if.req_ready), dat_t'(1));
        step();
        idle_a();
        idle_b();
`endif
        check("t3_rden_b", dat_t'(rden_b), dat_t'(1));
        step();
        check("t3_b_vld_t2", dat_t'(b_if.rsp_valid), '0);
        step();
        check("t3_b_vld_t3", dat_t'(b_if.rsp_valid), dat_t'(1));
        check("t3_b_data", b_if.rsp_rdata, 72'h333);
        step();

        // Credit exhaustion: 6 back-to-back reads with no consumer, 4 accepted.
        t4_addr = '{12'h010, 12'h020, 12'h030, 12'h010, 12'h020, 12'h030};
        t4_exp  = '{72'h0A5, 72'h222, 72'h333, 72'h0A5};
        a_if.rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_a('{we: 1'b0, addr: t4_addr[acc], wdata: '0});
            #1 if (a_if.req_ready) acc++;
            step();
        end
        check("t4_accepted", dat_t'(acc), dat_t'(4));
        check("t4_ready_low", dat_t'(a_if.req_ready), '0);
        check("t4_cred_zero", dat_t'(dut.u_rsp_a.cred), '0);
        idle_a();
        a_if.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_drain_vld", dat_t'(a_if.rsp_valid), dat_t'(1));
            check("t4_drain_data", a_if.rsp_rdata, t4_exp[k]);
            step();
        end
        check("t4_empty", dat_t'(a_if.rsp_valid), '0);
        check("t4_cred_back", dat_t'(dut.u_rsp_a.cred), dat_t'(RSP_DEPTH));

        // Reset with two reads in flight.
        drive_a('{we: 1'b0, addr: 12'h010, wdata: '0});
        step();
        drive_a('{we: 1'b0, addr: 12'h020, wdata: '0});
        step();
        idle_a();
        rst = 1'b1;
        #1;
        check("t5_rst_ready", dat_t'(a_if.req_ready), '0);
        check("t5_rst_rsp_vld", dat_t'(a_if.rsp_valid), '0);
        step();
        rst = 1'b0;
        #1;
        check("t5_ram_en", dat_t'({wren_a, rden_a, wren_b, rden_b}), '0);
        check("t5_addr_a", dat_t'(addr_a), '0);
        check("t5_wdata_a", wdata_a, '0);
        check("t5_cred_a", dat_t'(dut.u_rsp_a.cred), dat_t'(RSP_DEPTH));
        check("t5_cred_b", dat_t'(dut.u_rsp_b.cred), dat_t'(RSP_DEPTH));
        step();
        step();
        check("t5_no_stale_rsp", dat_t'(a_if.rsp_valid), '0);
        a_read_expect("t5_rd", 12'h030, 72'h333);
        step();

        // Random dual-port traffic over a small address window.
        for (int i = 0; i < 8; i++) begin
            drive_a('{we: 1'b1, addr: adr_t'(i), wdata: dat_t'(72'h1000 + i)});
            step();
        end
        idle_a();
        for (int n = 0; n < 3000; n++) begin
            rq = '{we: 1'($urandom_range(0, 1)), addr: adr_t'($urandom_range(0, 7)),
                   wdata: dat_t'({$urandom, $urandom, $urandom})};
            if ($urandom_range(0, 3) != 0) drive_a(rq); else idle_a();
            rq = '{we: 1'($urandom_range(0, 1)), addr: adr_t'($urandom_range(0, 7)),
                   wdata: dat_t'({$urandom, $urandom, $urandom})};
            if ($urandom_range(0, 3) != 0) drive_b(rq); else idle_b();
            a_if.rsp_ready = ($urandom_range(0, 3) != 0);
            b_if.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_a();
        idle_b();
        a_if.rsp_ready = 1'b1;
        b_if.rsp_ready = 1'b1;
        repeat (10) step();
        check("rand_a_drained", dat_t'(qa.size()), '0);
        check("rand_b_drained", dat_t'(qb.size()), '0);
        check("rand_cred_a", dat_t'(dut.u_rsp_a.cred), dat_t'(RSP_DEPTH));
        check("rand_cred_b", dat_t'(dut.u_rsp_b.cred), dat_t'(RSP_DEPTH));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
